// File: rtl/rbm_gibbs_sequencer.sv
// rbm_gibbs_sequencer
//   Runs CD-k Gibbs sampling over one shared RBM layer datapath. The layer
//   alternates between two directions:
//     forward  (visible -> hidden)
//     backward (hidden -> visible)
//   Chain: v0 -> h0 -> v1 -> ... -> vk -> hk.
//   The statistics v0/h0/vk/hk are committed together when a run completes.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   start, k_steps, v_in      run request; k_steps/v_in are sampled with an accepted start
//   abort                     synchronous return to idle; no done, no result update
//   busy, done                run in progress / one-cycle completion pulse
//   layer_issue, layer_dir    pass launch pulse and direction (0 fwd, 1 bwd)
//   layer_vis, layer_hid      operands to the layer (current visible/hidden state)
//   layer_hid_sample          forward-pass result from the layer
//   layer_vis_sample          backward-pass result from the layer
//   v0_out, h0_out            CD statistics from the start of the chain
//   vk_out, hk_out            CD statistics from the end of the chain
module rbm_gibbs_sequencer #(
  parameter int unsigned vis_dim        = 6,
  parameter int unsigned hid_dim        = 5,
  parameter int unsigned layer_latency  = 2,
  parameter int unsigned step_bitlength = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [step_bitlength-1:0] k_steps,
  input  logic [vis_dim-1:0]        v_in,
  output logic                      busy,
  output logic                      done,
  output logic                      layer_issue,
  output logic                      layer_dir,
  output logic [vis_dim-1:0]        layer_vis,
  output logic [hid_dim-1:0]        layer_hid,
  input  logic [hid_dim-1:0]        layer_hid_sample,
  input  logic [vis_dim-1:0]        layer_vis_sample,
  output logic [vis_dim-1:0]        v0_out,
  output logic [hid_dim-1:0]        h0_out,
  output logic [vis_dim-1:0]        vk_out,
  output logic [hid_dim-1:0]        hk_out
);

  localparam int unsigned LatW = $clog2(layer_latency + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFwdIssue,
    StFwdWait,
    StBwdIssue,
    StBwdWait,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [LatW-1:0]           lat_q, lat_d;
  logic [step_bitlength-1:0] step_q, step_d;
  logic [step_bitlength-1:0] k_q, k_d;
  logic [vis_dim-1:0]        v_cur_q, v_cur_d;
  logic [hid_dim-1:0]        h_cur_q, h_cur_d;
  logic [vis_dim-1:0]        v0_q, v0_d;
  logic [hid_dim-1:0]        h0_q, h0_d;
  logic [vis_dim-1:0]        v0_out_q, v0_out_d;
  logic [hid_dim-1:0]        h0_out_q, h0_out_d;
  logic [vis_dim-1:0]        vk_out_q, vk_out_d;
  logic [hid_dim-1:0]        hk_out_q, hk_out_d;

  logic run_abort;
  logic lat_last;

  assign run_abort = abort && (state_q != StIdle);
  assign lat_last  = (lat_q == LatW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      step_q   <= '0;
      k_q      <= '0;
      v_cur_q  <= '0;
      h_cur_q  <= '0;
      v0_q     <= '0;
      h0_q     <= '0;
      v0_out_q <= '0;
      h0_out_q <= '0;
      vk_out_q <= '0;
      hk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      step_q   <= step_d;
      k_q      <= k_d;
      v_cur_q  <= v_cur_d;
      h_cur_q  <= h_cur_d;
      v0_q     <= v0_d;
      h0_q     <= h0_d;
      v0_out_q <= v0_out_d;
      h0_out_q <= h0_out_d;
      vk_out_q <= vk_out_d;
      hk_out_q <= hk_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    step_d   = step_q;
    k_d      = k_q;
    v_cur_d  = v_cur_q;
    h_cur_d  = h_cur_q;
    v0_d     = v0_q;
    h0_d     = h0_q;
    v0_out_d = v0_out_q;
    h0_out_d = h0_out_q;
    vk_out_d = vk_out_q;
    hk_out_d = hk_out_q;

    busy        = 1'b0;
    done        = 1'b0;
    layer_issue = 1'b0;
    layer_dir   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort takes priority, so a start in the same cycle is dropped
        if (start && !abort) begin
          v0_d    = v_in;
          v_cur_d = v_in;
          k_d     = (k_steps == '0) ? step_bitlength'(1) : k_steps;
          step_d  = '0;
          state_d = StFwdIssue;
        end
      end
      StFwdIssue: begin
        busy = 1'b1;
        // Suppress the launch on abort so no orphan pass overlaps a later run
        layer_issue = !abort;
        lat_d = LatW'(layer_latency);
        state_d = StFwdWait;
      end
      StFwdWait: begin
        busy  = 1'b1;
        lat_d = lat_q - LatW'(1);
        if (lat_last) begin
          h_cur_d = layer_hid_sample;
          if (step_q == '0) h0_d = layer_hid_sample;
          if (step_q == k_q) begin
            // k >= 1, so h0 was captured on an earlier forward pass
            v0_out_d = v0_q;
            h0_out_d = h0_q;
            vk_out_d = v_cur_q;
            hk_out_d = layer_hid_sample;
            state_d  = StDone;
          end else begin
            state_d = StBwdIssue;
          end
        end
      end
      StBwdIssue: begin
        busy        = 1'b1;
        layer_dir   = 1'b1;
        layer_issue = !abort;
        lat_d       = LatW'(layer_latency);
        state_d     = StBwdWait;
      end
      StBwdWait: begin
        busy      = 1'b1;
        layer_dir = 1'b1;
        lat_d     = lat_q - LatW'(1);
        if (lat_last) begin
          v_cur_d = layer_vis_sample;
          step_d  = step_q + step_bitlength'(1);
          state_d = StFwdIssue;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort discards everything this cycle would have committed
    if (run_abort) begin
      state_d  = StIdle;
      v0_out_d = v0_out_q;
      h0_out_d = h0_out_q;
      vk_out_d = vk_out_q;
      hk_out_d = hk_out_q;
    end
  end

  assign layer_vis = v_cur_q;
  assign layer_hid = h_cur_q;
  assign v0_out    = v0_out_q;
  assign h0_out    = h0_out_q;
  assign vk_out    = vk_out_q;
  assign hk_out    = hk_out_q;

endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
module tb_rbm_gibbs_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [7:0] k_steps = '0;
  logic [5:0] v_in = '0;

  // DUT A: latency 2, DUT B: latency 1
  logic       a_busy, a_done, a_issue, a_dir, b_busy, b_done, b_issue, b_dir;
  logic [5:0] a_vis, b_vis, a_vs, b_vs, a_v0, b_v0, a_vk, b_vk;
  logic [4:0] a_hid, b_hid, a_hs, b_hs, a_h0, b_h0, a_hk, b_hk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_v0[2], exp_vk[2];
  logic [4:0] exp_h0[2], exp_hk[2];

  always #5 clock = ~clock;

  function automatic logic [4:0] fwd(input logic [5:0] v);
    return v[4:0] ^ 5'b10101;
  endfunction

  function automatic logic [5:0] bwd(input logic [4:0] h);
    return {h, h[0]};
  endfunction

  rbm_gibbs_sequencer #(.vis_dim(6), .hid_dim(5), .layer_latency(2), .step_bitlength(8)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort), .k_steps(k_steps),
    .v_in(v_in), .busy(a_busy), .done(a_done), .layer_issue(a_issue), .layer_dir(a_dir),
    .layer_vis(a_vis), .layer_hid(a_hid), .layer_hid_sample(a_hs), .layer_vis_sample(a_vs),
    .v0_out(a_v0), .h0_out(a_h0), .vk_out(a_vk), .hk_out(a_hk)
  );

  rbm_gibbs_sequencer #(.vis_dim(6), .hid_dim(5), .layer_latency(1), .step_bitlength(8)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort), .k_steps(k_steps),
    .v_in(v_in), .busy(b_busy), .done(b_done), .layer_issue(b_issue), .layer_dir(b_dir),
    .layer_vis(b_vis), .layer_hid(b_hid), .layer_hid_sample(b_hs), .layer_vis_sample(b_vs),
    .v0_out(b_v0), .h0_out(b_h0), .vk_out(b_vk), .hk_out(b_hk)
  );

  // Mock layers: operands captured at issue, result valid only on the cycle
  // exactly `latency` cycles after issue; random garbage at all other times.
  int         a_cnt = 0, b_cnt = 0;
  logic       a_rdir = 1'b0, b_rdir = 1'b0;
  logic [5:0] a_rv = '0, b_rv = '0;
  logic [4:0] a_rh = '0, b_rh = '0;
  logic [31:0] garb = '0;

  always @(posedge clock) begin
    garb <= $urandom;
    if (a_issue) begin
      a_cnt <= 2; a_rdir <= a_dir; a_rv <= a_vis; a_rh <= a_hid;
    end else if (a_cnt != 0) a_cnt <= a_cnt - 1;
    if (b_issue) begin
      b_cnt <= 1; b_rdir <= b_dir; b_rv <= b_vis; b_rh <= b_hid;
    end else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end

  assign a_hs = (a_cnt == 1 && !a_rdir) ? fwd(a_rv) : garb[4:0];
  assign a_vs = (a_cnt == 1 &&  a_rdir) ? bwd(a_rh) : garb[10:5];
  assign b_hs = (b_cnt == 1 && !b_rdir) ? fwd(b_rv) : garb[15:11];
  assign b_vs = (b_cnt == 1 &&  b_rdir) ? bwd(b_rh) : garb[21:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 re-assert start at cycles 3 and 5; abort_at>0 aborts at that cycle.
  // Cycle 0 is the edge accepting start; cycle n is the interval after edge n.
  task automatic run(input int sel, input logic [5:0] v, input logic [7:0] k, input int mode,
                     input int abort_at, input string tag);
    int lat, keff, exp_done, bound, done_at, issues, seq_err, busy_after;
    logic [5:0] vv;
    logic [4:0] hh, h0m;
    logic b, d, is, dr;
    lat = (sel == 1) ? 1 : 2;
    keff = (k == 0) ? 1 : int'(k);
    exp_done = 1 + (2 * keff + 1) * (lat + 1);
    bound = exp_done + 20;
    done_at = -1; issues = 0; seq_err = 0; busy_after = -1;
    // Reference chain v0 -> h0 -> v1 -> ... -> vk -> hk
    vv = v; hh = fwd(vv); h0m = hh;
    for (int i = 1; i <= keff; i++) begin
      vv = bwd(hh); hh = fwd(vv);
    end
    @(negedge clock);
    v_in = v; k_steps = k;
    if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clock);
      b  = (sel == 1) ? b_busy  : a_busy;
      d  = (sel == 1) ? b_done  : a_done;
      is = (sel == 1) ? b_issue : a_issue;
      dr = (sel == 1) ? b_dir   : a_dir;
      if (is) begin
        if (n != 1 + issues * (lat + 1) || dr !== issues[0]) seq_err++;
        issues++;
      end
      if (abort_at == 0) begin
        if (n < exp_done && b !== 1'b1) seq_err++;
        if (n == exp_done && b !== 1'b0) seq_err++;
      end
      if (n == abort_at + 1) busy_after = int'(b);
      start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
      if (mode == 1 && (n == 3 || n == 5)) begin
        v_in = 6'($urandom); k_steps = 8'($urandom);
        if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
      end
      if (n == abort_at) abort = 1'b1;
      if (d === 1'b1) begin
        done_at = n;
        break;
      end
    end
    if (abort_at == 0) begin
      exp_v0[sel] = v; exp_h0[sel] = h0m; exp_vk[sel] = vv; exp_hk[sel] = hh;
      chk({tag, "_done_cycle"}, done_at, exp_done);
      chk({tag, "_issue_count"}, issues, 2 * keff + 1);
      @(negedge clock);
      chk({tag, "_done_pulse"}, (sel == 1) ? b_done : a_done, 0);
    end else begin
      chk({tag, "_no_done"}, done_at, -1);
      chk({tag, "_idle_after_abort"}, busy_after, 0);
    end
    chk({tag, "_issue_seq_err"}, seq_err, 0);
    chk({tag, "_v0"}, (sel == 1) ? b_v0 : a_v0, exp_v0[sel]);
    chk({tag, "_h0"}, (sel == 1) ? b_h0 : a_h0, exp_h0[sel]);
    chk({tag, "_vk"}, (sel == 1) ? b_vk : a_vk, exp_vk[sel]);
    chk({tag, "_hk"}, (sel == 1) ? b_hk : a_hk, exp_hk[sel]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_v0[i] = '0; exp_h0[i] = '0; exp_vk[i] = '0; exp_hk[i] = '0;
    end
    repeat (3) @(negedge clock);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_issue", a_issue, 0);
    chk("rst_layer_vis", a_vis, 0);
    chk("rst_hk", a_hk, 0);
    chk("rst_b_v0", b_v0, 0);
    reset = 1'b1;
    @(negedge clock);

    // Directed case from the datapath table
    run(0, 6'b000011, 8'd1, 0, 0, "k1");
    chk("k1_h0_const", a_h0, 5'b10110);
    chk("k1_vk_const", a_vk, 6'b101100);
    chk("k1_hk_const", a_hk, 5'b11001);
    run(0, 6'b000011, 8'd0, 0, 0, "k0_clamp");
    run(1, 6'b000011, 8'd3, 0, 0, "lat1_k3");
    chk("lat1_k3_h0_same", b_h0, 5'b10110);
    run(0, 6'($urandom), 8'd2, 1, 0, "start_ignored");
    run(0, 6'($urandom), 8'd1, 0, 5, "abort");
    run(0, 6'($urandom), 8'd1, 0, 0, "after_abort");

    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(0, 1)), 6'($urandom), 8'($urandom_range(0, 5)), 0, 0, "rand");
    end

    run(1, 6'($urandom), 8'd255, 0, 0, "k_max");

    // Asynchronous reset in the middle of FWD_WAIT
    @(negedge clock);
    v_in = 6'b110001; k_steps = 8'd1; start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", a_busy, 0);
    chk("async_issue", a_issue, 0);
    chk("async_vis", a_vis, 0);
    chk("async_outs", {a_v0, a_h0, a_vk, a_hk}, 0);
    chk("async_b_outs", {b_v0, b_h0, b_vk, b_hk}, 0);
    for (int i = 0; i < 2; i++) begin
      exp_v0[i] = '0; exp_h0[i] = '0; exp_vk[i] = '0; exp_hk[i] = '0;
    end
    @(negedge clock);
    reset = 1'b1;
    run(0, 6'($urandom), 8'd2, 0, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
